float_to_fixed: RTL and testbench
=================================

FLOAT_TO_FIXED -- requirements
Module: float_to_fixed

Interface
REQ-001 SHALL have parameter FRAC_BITS, default 16, meaning fractional bits of the signed 32-bit fixed-point result; legal range 0..30.
REQ-002 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_ni, input, 1 bit, meaning reset; reset is asynchronous and active-low.
REQ-004 SHALL have port a_value_i, input, 32 bits, meaning IEEE-754 single operand, typically an fpu adder z_value_o.
REQ-005 SHALL have port exec_strobe_i, input, 1 bit, meaning start request.
REQ-006 SHALL have port z_value_o, output, 32 bits, meaning two's-complement fixed-point result with FRAC_BITS fraction bits.
REQ-007 SHALL have port overflow_o, output, 1 bit, meaning the result was saturated.
REQ-008 SHALL have port invalid_o, output, 1 bit, meaning the operand was NaN.
REQ-009 SHALL have port done_strobe_o, output, 1 bit, meaning a one-cycle pulse marking z_value_o, overflow_o and invalid_o valid.

Function
REQ-010 SHALL use states IDLE, UNPACK, SPECIAL_CASES, SHIFT, ROUND, PACK, DONE.
REQ-011 SHALL capture a_value_i in IDLE when exec_strobe_i=1 (cycle 0); exec_strobe_i SHALL be ignored in every other state.
REQ-012 UNPACK (cycle 1) SHALL extract sign s, unbiased exponent e=E-127 (10-bit signed), and 24-bit mantissa m={1,frac}; shift k=e-23+FRAC_BITS.
REQ-013 SPECIAL_CASES (cycle 2) decisions, all then going to DONE:
- NaN: z=0, invalid_o=1.
- +Inf: z=0x7FFFFFFF, overflow_o=1; -Inf: z=0x80000000, overflow_o=1.
- Zero or denormal: z=0.
- e+FRAC_BITS>31, or e+FRAC_BITS=31 unless (s=1 and frac=0): saturate by sign, overflow_o=1.
- e+FRAC_BITS=31, s=1, frac=0: z=0x80000000, overflow_o=0.
- e<=-FRAC_BITS-2: z=0.
REQ-014 Otherwise SHALL enter SHIFT if k!=0, else ROUND.
REQ-015 SHIFT SHALL move the 32-bit magnitude one bit per cycle, |k| cycles total.
- k>0: shift left.
- k<0: shift right, collecting guard, round and sticky (sticky ORs all lower bits).
REQ-016 ROUND SHALL round to nearest, ties to even: increment when guard and (round | sticky | lsb).
REQ-017 PACK SHALL negate the magnitude when s=1; a positive rounded magnitude reaching 2^31 SHALL saturate to 0x7FFFFFFF with overflow_o=1.
REQ-018 DONE SHALL set done_strobe_o=1 for exactly the next cycle and return to IDLE.
REQ-019 Latency: done_strobe_o high in cycle 6+|k| for the shift path and cycle 4 for special cases; a new exec_strobe_i is accepted in the done_strobe_o cycle.
REQ-020 z_value_o, overflow_o and invalid_o SHALL hold their values until the next PACK or SPECIAL_CASES update.

Reset
REQ-021 Assertion of reset_ni=0 SHALL immediately force state=IDLE and done_strobe_o=0, z_value_o=0, overflow_o=0, invalid_o=0, including mid-conversion.
REQ-022 After deassertion, the first exec_strobe_i sampled in IDLE SHALL start a clean conversion with no residue from an aborted one.

Structure
REQ-023 The state enum and IEEE field constants (bias 127, exponent all-ones 255) SHALL live in the shared fpu package used by the fpu blocks.
REQ-024 SHALL be a single module with no sub-module; rounding is inline in ROUND.

Verification (FRAC_BITS=16)
REQ-025 0x3F800000 (1.0) -> z=0x00010000, no flags, done in cycle 13 (k=-7); -2.5 (0xC0200000) -> z=0xFFFD8000.
REQ-026 0x37000000 (2^-17, exact tie) -> z=0; 0x37400000 (0.75 ulp) -> z=0x00000001.
REQ-027 0x47800000 (65536.0) -> z=0x7FFFFFFF, overflow_o=1; 0xC7000000 (-32768.0) -> z=0x80000000, overflow_o=0.
REQ-028 0x7FC00000 (NaN) -> z=0, invalid_o=1; 0xFF800000 (-Inf) -> z=0x80000000, overflow_o=1; both done in cycle 4.
REQ-029 Reset pulsed during SHIFT of 1.0, then 0x40000000 (2.0) -> only one done_strobe_o, z=0x00020000.
REQ-030 Back-to-back: second exec_strobe_i in the done cycle is accepted; exec_strobe_i held high while busy produces no extra conversions.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared package for the fpu blocks.
// Holds the IEEE-754 single-precision field constants and the state
// encoding of the float-to-fixed converter FSM.
package fpu_pkg;

  // IEEE-754 single-precision field constants
  localparam int          FP_BIAS    = 127;
  localparam int          FP_MANT_W  = 23;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;

  // Converter FSM states, in the order a conversion walks through them
  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    SPECIAL_CASES,
    SHIFT,
    ROUND,
    PACK,
    DONE
  } f2x_state_e;

endpackage

// File: rtl/float_to_fixed.sv
// float_to_fixed
// Converts an IEEE-754 single-precision operand into a signed 32-bit
// two's-complement fixed-point value with FRAC_BITS fraction bits.
// The magnitude is aligned one bit per cycle and rounded to nearest,
// ties to even.
//
// Ports:
//   clk           - clock, all state updates on its rising edge
//   reset_ni      - asynchronous active-low reset
//   a_value_i     - IEEE-754 single operand, captured on exec_strobe_i in IDLE
//   exec_strobe_i - start request, ignored while a conversion is in flight
//   z_value_o     - fixed-point result
//   overflow_o    - result was saturated
//   invalid_o     - operand was NaN
//   done_strobe_o - one-cycle pulse marking the outputs valid
module float_to_fixed
  import fpu_pkg::*;
#(
  parameter int FRAC_BITS = 16
) (
  input  logic        clk,
  input  logic        reset_ni,
  input  logic [31:0] a_value_i,
  input  logic        exec_strobe_i,
  output logic [31:0] z_value_o,
  output logic        overflow_o,
  output logic        invalid_o,
  output logic        done_strobe_o
);

  localparam logic signed [9:0] BIAS_S = 10'(FP_BIAS);
  localparam logic signed [9:0] MANT_S = 10'(FP_MANT_W);
  localparam logic signed [9:0] FRAC_S = 10'(FRAC_BITS);

  f2x_state_e state_q, state_d;

  logic [31:0]       operand_q;
  logic              sign_q;
  logic [7:0]        exp_q;
  logic [22:0]       frac_q;
  logic signed [9:0] e_q;
  logic signed [9:0] k_q;
  logic [31:0]       mag_q;
  logic              guard_q, round_q, sticky_q;
  logic [9:0]        shift_cnt_q;
  logic              shift_left_q;

  logic signed [9:0] unpack_e;
  logic signed [9:0] unpack_k;
  logic signed [9:0] e_plus_f;
  logic [9:0]        abs_k;
  logic              round_inc;

  logic              special_hit;
  logic [31:0]       special_z;
  logic              special_ovf;
  logic              special_inv;
  logic [31:0]       sat_z;

  assign unpack_e  = $signed({2'b00, operand_q[30:23]}) - BIAS_S;
  assign unpack_k  = unpack_e - MANT_S + FRAC_S;
  assign e_plus_f  = e_q + FRAC_S;
  assign abs_k     = k_q[9] ? -k_q : k_q;
  assign round_inc = guard_q & (round_q | sticky_q | mag_q[0]);
  assign sat_z     = sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;

  // Classify the unpacked operand. The exponent checks come first because
  // an all-ones or all-zero biased exponent would otherwise look like an
  // ordinary huge or tiny number to the range checks below. A result with
  // e+FRAC_BITS=31 only fits when it is exactly -2^31.
  always_comb begin
    special_hit = 1'b1;
    special_z   = 32'h0000_0000;
    special_ovf = 1'b0;
    special_inv = 1'b0;
    if (exp_q == FP_EXP_MAX) begin
      if (frac_q != 23'd0) begin
        special_inv = 1'b1;
      end else begin
        special_z   = sat_z;
        special_ovf = 1'b1;
      end
    end else if (exp_q == 8'd0) begin
      special_z = 32'h0000_0000;
    end else if ((e_plus_f > 10'sd31) ||
                 ((e_plus_f == 10'sd31) && !(sign_q && (frac_q == 23'd0)))) begin
      special_z   = sat_z;
      special_ovf = 1'b1;
    end else if (e_plus_f == 10'sd31) begin
      special_z = 32'h8000_0000;
    end else if (e_plus_f <= -10'sd2) begin
      special_z = 32'h0000_0000;
    end else begin
      special_hit = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the shift counter holds the remaining cycles of
  // alignment, so leaving SHIFT happens on its last count.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:          if (exec_strobe_i) state_d = UNPACK;
      UNPACK:        state_d = SPECIAL_CASES;
      SPECIAL_CASES: begin
        if (special_hit)         state_d = DONE;
        else if (k_q != 10'sd0)  state_d = SHIFT;
        else                     state_d = ROUND;
      end
      SHIFT:         if (shift_cnt_q == 10'd1) state_d = ROUND;
      ROUND:         state_d = PACK;
      PACK:          state_d = DONE;
      DONE:          state_d = IDLE;
      default:       state_d = IDLE;
    endcase
  end

  // Datapath. Every working register is cleared by reset and reloaded
  // in UNPACK, so an aborted conversion leaves nothing behind.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      operand_q     <= 32'h0000_0000;
      sign_q        <= 1'b0;
      exp_q         <= 8'd0;
      frac_q        <= 23'd0;
      e_q           <= 10'sd0;
      k_q           <= 10'sd0;
      mag_q         <= 32'h0000_0000;
      guard_q       <= 1'b0;
      round_q       <= 1'b0;
      sticky_q      <= 1'b0;
      shift_cnt_q   <= 10'd0;
      shift_left_q  <= 1'b0;
      z_value_o     <= 32'h0000_0000;
      overflow_o    <= 1'b0;
      invalid_o     <= 1'b0;
      done_strobe_o <= 1'b0;
    end else begin
      done_strobe_o <= (state_q == DONE);
      unique case (state_q)
        IDLE: begin
          if (exec_strobe_i) operand_q <= a_value_i;
        end
        UNPACK: begin
          sign_q   <= operand_q[31];
          exp_q    <= operand_q[30:23];
          frac_q   <= operand_q[22:0];
          e_q      <= unpack_e;
          k_q      <= unpack_k;
          mag_q    <= {8'h00, 1'b1, operand_q[22:0]};
          guard_q  <= 1'b0;
          round_q  <= 1'b0;
          sticky_q <= 1'b0;
        end
        SPECIAL_CASES: begin
          shift_cnt_q  <= abs_k;
          shift_left_q <= ~k_q[9];
          if (special_hit) begin
            z_value_o  <= special_z;
            overflow_o <= special_ovf;
            invalid_o  <= special_inv;
          end
        end
        SHIFT: begin
          // Right shifts feed the dropped bit into guard, guard into round,
          // and round into the sticky OR of everything further below.
          shift_cnt_q <= shift_cnt_q - 10'd1;
          if (shift_left_q) begin
            mag_q <= {mag_q[30:0], 1'b0};
          end else begin
            mag_q    <= {1'b0, mag_q[31:1]};
            guard_q  <= mag_q[0];
            round_q  <= guard_q;
            sticky_q <= sticky_q | round_q;
          end
        end
        ROUND: begin
          mag_q <= mag_q + {31'd0, round_inc};
        end
        PACK: begin
          invalid_o <= 1'b0;
          if (sign_q) begin
            z_value_o  <= -mag_q;
            overflow_o <= 1'b0;
          end else if (mag_q[31]) begin
            z_value_o  <= 32'h7FFF_FFFF;
            overflow_o <= 1'b1;
          end else begin
            z_value_o  <= mag_q;
            overflow_o <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_float_to_fixed.sv
// Directed testbench for float_to_fixed with FRAC_BITS=16.
module tb_float_to_fixed;

  localparam int FRAC_BITS = 16;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic [31:0] a_value_i;
  logic        exec_strobe_i;
  logic [31:0] z_value_o;
  logic        overflow_o;
  logic        invalid_o;
  logic        done_strobe_o;

  int checks = 0;
  int errors = 0;
  int done_count = 0;
  int lat;
  int base;

  float_to_fixed #(.FRAC_BITS(FRAC_BITS)) dut (
    .clk           (clk),
    .reset_ni      (reset_ni),
    .a_value_i     (a_value_i),
    .exec_strobe_i (exec_strobe_i),
    .z_value_o     (z_value_o),
    .overflow_o    (overflow_o),
    .invalid_o     (invalid_o),
    .done_strobe_o (done_strobe_o)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Count done pulses just after each rising edge
  always @(posedge clk) begin
    #1;
    if (done_strobe_o === 1'b1) done_count++;
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Starts a conversion at a falling edge and returns at the falling edge
  // of the done cycle. Cycle 0 is the cycle in which exec_strobe_i is seen.
  task automatic convert(input logic [31:0] a, input bit hold, output int cycles);
    a_value_i     = a;
    exec_strobe_i = 1'b1;
    @(negedge clk);
    cycles = 1;
    if (!hold) exec_strobe_i = 1'b0;
    while (done_strobe_o !== 1'b1 && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    exec_strobe_i = 1'b0;
  endtask

  task automatic check_conv(input string tag, input logic [31:0] a, input logic [31:0] exp_z,
                            input logic exp_ovf, input logic exp_inv, input int exp_lat);
    int c;
    convert(a, 1'b0, c);
    check_int({tag, " latency"}, c, exp_lat);
    check32({tag, " z"}, z_value_o, exp_z);
    check32({tag, " overflow"}, {31'd0, overflow_o}, {31'd0, exp_ovf});
    check32({tag, " invalid"}, {31'd0, invalid_o}, {31'd0, exp_inv});
  endtask

  // Directed sequence; consecutive check_conv calls start the next
  // conversion in the done cycle of the previous one.
  initial begin
    reset_ni      = 1'b0;
    exec_strobe_i = 1'b0;
    a_value_i     = 32'h0;
    repeat (3) @(negedge clk);
    check32("reset z", z_value_o, 32'h0);
    check32("reset flags", {29'd0, overflow_o, invalid_o, done_strobe_o}, 32'h0);
    reset_ni = 1'b1;
    @(negedge clk);

    $display("[TB] basic conversions");
    check_conv("one",        32'h3F80_0000, 32'h0001_0000, 1'b0, 1'b0, 13);
    check_conv("neg2p5",     32'hC020_0000, 32'hFFFD_8000, 1'b0, 1'b0, 12);
    check_conv("tie_even0",  32'h3700_0000, 32'h0000_0000, 1'b0, 1'b0, 30);
    check_conv("above_tie",  32'h3740_0000, 32'h0000_0001, 1'b0, 1'b0, 30);
    check_conv("tie_odd",    32'h37C0_0000, 32'h0000_0002, 1'b0, 1'b0, 29);
    check_conv("k_zero",     32'h4300_0000, 32'h0080_0000, 1'b0, 1'b0, 6);
    check_conv("left_shift", 32'h46C0_0000, 32'h6000_0000, 1'b0, 1'b0, 13);

    $display("[TB] special cases");
    check_conv("too_big",    32'h4780_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 4);
    check_conv("min_int",    32'hC700_0000, 32'h8000_0000, 1'b0, 1'b0, 4);
    check_conv("neg_big",    32'hC701_0000, 32'h8000_0000, 1'b1, 1'b0, 4);
    check_conv("nan",        32'h7FC0_0000, 32'h0000_0000, 1'b0, 1'b1, 4);
    check_conv("neg_inf",    32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 4);
    check_conv("tiny",       32'h3680_0000, 32'h0000_0000, 1'b0, 1'b0, 4);
    check_conv("pos_inf",    32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 4);
    check_conv("zero",       32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 4);

    // Leave a nonzero result in place so reset clearing it is visible
    check_conv("pre_reset",  32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 4);
    @(negedge clk);
    check32("single pulse", {31'd0, done_strobe_o}, 32'h0);

    $display("[TB] reset during shift");
    a_value_i     = 32'h3F80_0000;
    exec_strobe_i = 1'b1;
    @(negedge clk);
    exec_strobe_i = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_ni = 1'b0;
    #1;
    check32("async reset z", z_value_o, 32'h0);
    check32("async reset flags", {29'd0, overflow_o, invalid_o, done_strobe_o}, 32'h0);
    @(negedge clk);
    reset_ni = 1'b1;
    @(negedge clk);
    base = done_count;
    check_conv("after_reset", 32'h4000_0000, 32'h0002_0000, 1'b0, 1'b0, 12);
    repeat (20) @(negedge clk);
    check_int("done pulses after reset", done_count - base, 1);

    $display("[TB] exec held high while busy");
    base = done_count;
    convert(32'h3F80_0000, 1'b1, lat);
    check_int("hold latency", lat, 13);
    check32("hold z", z_value_o, 32'h0001_0000);
    repeat (30) @(negedge clk);
    check_int("hold done pulses", done_count - base, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
